// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer in front of the
// single-ported data_memory. Port 0 is the core load/store path, port 1 the
// loader/debug master. Each accepted request is latched, range/alignment
// checked, issued as one word access and answered with one response pulse.
//
// Configuration macro: DMEM_ARB_RR_EN
//   defined   -> round-robin arbitration on contention
//   undefined -> fixed priority, port 0 wins contention

module dmem_arbiter #(
  parameter int unsigned     AW   = 32,
  parameter int unsigned     DW   = 32,
  parameter logic [AW-1:0]   BASE = 'h1000,
  parameter int unsigned     SIZE = 1024
) (
  input  logic          clk,
  input  logic          rst,
  // port 0
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  // port 1
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  // memory side
  output logic [AW-1:0] mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Bounds are held in AW+1 bits so BASE+SIZE cannot wrap around.
  localparam logic [AW:0] LO_ADDR = {1'b0, BASE};
  localparam logic [AW:0] HI_ADDR = LO_ADDR + (AW+1)'(SIZE - 4);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;

  // Latched request
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_port;

  // Arbitration result for the current IDLE cycle
  logic          grant_valid;
  logic          grant_port;

  // Access qualification
  logic          addr_err;
  logic          access;

  // Response being formed during ACCESS
  logic [DW-1:0] resp_data;

`ifdef DMEM_ARB_RR_EN
  // Port that has priority on the next contention.
  logic          rr_ptr;
`endif

  // Next-state and grant decode.
  always_comb begin
    // NOTE: every combinational output gets a default first; otherwise a
    // path that skips an assignment infers a latch.
    state_next  = state;
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    unique case (state)
      IDLE: begin
        // No grant while in reset: the access would be dropped silently.
        if (!rst && (m0_req || m1_req)) begin
          grant_valid = 1'b1;
          if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
            grant_port = rr_ptr;
`else
            grant_port = 1'b0;
`endif
          end else begin
            grant_port = m1_req;
          end
          state_next = ACCESS;
        end
      end
      ACCESS: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    m0_gnt = grant_valid && !grant_port;
    m1_gnt = grant_valid &&  grant_port;
  end

  // Range and alignment check on the latched address.
  always_comb begin
    addr_err = (l_addr[1:0] != 2'b00)
            || ({1'b0, l_addr} < LO_ADDR)
            || ({1'b0, l_addr} > HI_ADDR);
  end

  // Memory-side drive; everything is zero outside a live ACCESS cycle, and
  // the reset term keeps a write from committing while rst is high.
  always_comb begin
    access      = (state == ACCESS) && !rst;
    mem_address = access ? l_addr  : '0;
    mem_wdata   = access ? l_wdata : '0;
    mem_read    = access && !addr_err && !l_we;
    mem_write   = access && !addr_err &&  l_we;
    resp_data   = mem_read ? mem_rdata : '0;
  end

  // State register and request latch.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its inputs from before the edge.
    if (rst) begin
      state   <= IDLE;
      l_we    <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_port  <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_valid) begin
        l_port  <= grant_port;
        l_we    <= grant_port ? m1_we    : m0_we;
        l_addr  <= grant_port ? m1_addr  : m0_addr;
        l_wdata <= grant_port ? m1_wdata : m0_wdata;
      end
    end
  end

  // Response registers: one pulse to the winner after its ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_err    <= 1'b0;
    end else begin
      m0_rvalid <= access && !l_port;
      m0_rdata  <= (access && !l_port) ? resp_data : '0;
      m0_err    <= access && !l_port && addr_err;
      m1_rvalid <= access &&  l_port;
      m1_rdata  <= (access &&  l_port) ? resp_data : '0;
      m1_err    <= access &&  l_port && addr_err;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer: the port just granted loses priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (grant_valid) begin
      rr_ptr <= ~grant_port;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural
// combinational-read word memory. Expected grant order follows
// DMEM_ARB_RR_EN when it is defined for the build.

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] tb_mem [256];

  int vectors    = 0;
  int miscompares = 0;

  // Results collected by issue()
  logic [1:0]  r_gnt;
  int          r_rd_cnt, r_wr_cnt;
  logic [31:0] r_acc_addr;
  logic        r_rv, r_other_rv, r_err;
  logic [31:0] r_rdata;

  logic [1:0]  g_obs [4];
  logic [1:0]  g_exp [4];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: BASE is 1 KiB aligned, so the word index is addr[9:2].
  assign mem_rdata = tb_mem[mem_address[9:2]];
  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_address[9:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction: grant cycle, ACCESS cycle, response cycle.
  task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
    @(negedge clk);
    r_gnt    = {m1_gnt, m0_gnt};
    r_rd_cnt = int'(mem_read);
    r_wr_cnt = int'(mem_write);
    next_cycle();
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    r_rd_cnt  += int'(mem_read);
    r_wr_cnt  += int'(mem_write);
    r_acc_addr = mem_address;
    next_cycle();
    @(negedge clk);
    r_rd_cnt  += int'(mem_read);
    r_wr_cnt  += int'(mem_write);
    r_rv       = port ? m1_rvalid : m0_rvalid;
    r_other_rv = port ? m0_rvalid : m1_rvalid;
    r_rdata    = port ? m1_rdata  : m0_rdata;
    r_err      = port ? m1_err    : m0_err;
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
    tb_mem[1]   = 32'hDEADBEEF;   // 'h1004
    tb_mem[8]   = 32'h11111111;   // 'h1020
    tb_mem[255] = 32'hCAFEF00D;   // 'h13FC
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

    // ---- reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    check("rst_err",    {30'd0, m1_err, m0_err}, 32'd0);
    check("rst_rdata0", m0_rdata, 32'd0);
    check("rst_rdata1", m1_rdata, 32'd0);
    check("rst_mem",    {30'd0, mem_read, mem_write}, 32'd0);
    next_cycle();
    rst = 1'b0;

    // ---- single read
    issue(1'b0, 1'b0, 32'h1004, 32'h0);
    check("rd_gnt",    {30'd0, r_gnt}, 32'd1);
    check("rd_memrd",  r_rd_cnt, 1);
    check("rd_addr",   r_acc_addr, 32'h1004);
    check("rd_rvalid", {31'd0, r_rv}, 32'd1);
    check("rd_data",   r_rdata, 32'hDEADBEEF);
    check("rd_err",    {31'd0, r_err}, 32'd0);
    check("rd_m1rv",   {31'd0, r_other_rv}, 32'd0);
    @(negedge clk);
    check("rd_pulse",  {31'd0, m0_rvalid}, 32'd0);
    next_cycle();

    // ---- write then read on port 1
    issue(1'b1, 1'b1, 32'h1010, 32'h12345678);
    check("wr_gnt",    {30'd0, r_gnt}, 32'd2);
    check("wr_once",   r_wr_cnt, 1);
    check("wr_rvalid", {31'd0, r_rv}, 32'd1);
    check("wr_rdata",  r_rdata, 32'd0);
    check("wr_err",    {31'd0, r_err}, 32'd0);
    check("wr_m0rv",   {31'd0, r_other_rv}, 32'd0);
    check("wr_mem",    tb_mem[4], 32'h12345678);
    issue(1'b1, 1'b0, 32'h1010, 32'h0);
    check("wrrd_data", r_rdata, 32'h12345678);

    // ---- contention: both ports hold req for 4 grants
`ifdef DMEM_ARB_RR_EN
    g_exp[0] = 2'b01; g_exp[1] = 2'b10; g_exp[2] = 2'b01; g_exp[3] = 2'b10;
`else
    g_exp[0] = 2'b01; g_exp[1] = 2'b01; g_exp[2] = 2'b01; g_exp[3] = 2'b01;
`endif
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1000;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h1008;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      g_obs[k] = {m1_gnt, m0_gnt};
      next_cycle();
      if (k == 3) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end
      @(negedge clk);
      check("cont_nognt_access", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      next_cycle();
    end
    for (int k = 0; k < 4; k++) check($sformatf("cont_gnt%0d", k), {30'd0, g_obs[k]}, {30'd0, g_exp[k]});
    next_cycle();

    // ---- address errors
    issue(1'b0, 1'b0, 32'h1002, 32'h0);
    check("e1002_err",  {31'd0, r_err}, 32'd1);
    check("e1002_data", r_rdata, 32'd0);
    check("e1002_mem",  r_rd_cnt + r_wr_cnt, 0);
    issue(1'b0, 1'b0, 32'h0FFC, 32'h0);
    check("e0ffc_err",  {31'd0, r_err}, 32'd1);
    check("e0ffc_data", r_rdata, 32'd0);
    check("e0ffc_mem",  r_rd_cnt + r_wr_cnt, 0);
    issue(1'b0, 1'b0, 32'h1400, 32'h0);
    check("e1400_err",  {31'd0, r_err}, 32'd1);
    check("e1400_rv",   {31'd0, r_rv}, 32'd1);
    check("e1400_data", r_rdata, 32'd0);
    check("e1400_mem",  r_rd_cnt + r_wr_cnt, 0);
    issue(1'b0, 1'b0, 32'h13FC, 32'h0);
    check("e13fc_err",  {31'd0, r_err}, 32'd0);
    check("e13fc_data", r_rdata, 32'hCAFEF00D);

    // ---- reset during the ACCESS cycle of a write
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h1020; m0_wdata = 32'h55AA55AA;
    @(negedge clk);
    check("rstw_gnt", {31'd0, m0_gnt}, 32'd1);
    next_cycle();
    m0_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstw_memwr", {31'd0, mem_write}, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rstw_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    check("rstw_out",    {28'd0, m0_err, m1_err, mem_read, mem_write}, 32'd0);
    check("rstw_rdata",  m0_rdata, 32'd0);
    check("rstw_addr",   mem_address, 32'd0);
    check("rstw_mem",    tb_mem[8], 32'h11111111);
    next_cycle();
    @(negedge clk);
    check("rstw_norv", {31'd0, m0_rvalid}, 32'd0);
    next_cycle();

    // ---- back-to-back reads on port 0
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1004;
    @(negedge clk);                                          // cycle 0
    check("b2b_gnt0", {31'd0, m0_gnt}, 32'd1);
    next_cycle();
    m0_addr = 32'h1010;
    @(negedge clk);                                          // cycle 1
    check("b2b_c1", {29'd0, m0_gnt, mem_read, m0_rvalid}, 32'b010);
    next_cycle();
    @(negedge clk);                                          // cycle 2
    check("b2b_c2", {29'd0, m0_gnt, mem_read, m0_rvalid}, 32'b101);
    check("b2b_d0", m0_rdata, 32'hDEADBEEF);
    next_cycle();
    m0_addr = 32'h13FC;
    @(negedge clk);                                          // cycle 3
    check("b2b_c3", {29'd0, m0_gnt, mem_read, m0_rvalid}, 32'b010);
    next_cycle();
    @(negedge clk);                                          // cycle 4
    check("b2b_c4", {29'd0, m0_gnt, mem_read, m0_rvalid}, 32'b101);
    check("b2b_d1", m0_rdata, 32'h12345678);
    next_cycle();
    m0_req = 1'b0;
    @(negedge clk);                                          // cycle 5
    check("b2b_c5", {29'd0, m0_gnt, mem_read, m0_rvalid}, 32'b010);
    next_cycle();
    @(negedge clk);                                          // cycle 6
    check("b2b_c6", {29'd0, m0_gnt, mem_read, m0_rvalid}, 32'b001);
    check("b2b_d2", m0_rdata, 32'hCAFEF00D);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
